// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: NOP encoding, FSM states, RS field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Source-register field positions inside an RV32I instruction word
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_stage_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the ID instruction.
// Latency: purely combinational.
// Backpressure: none; the result is what stalls fetch.
module hazard_detect
    import fetch_pkg::*;
(
    input  logic        is_load,
    input  logic [4:0]  wa,
    input  logic [31:0] instr,
    input  logic        valid,
    output logic        luse
);

    logic [4:0] rs1;
    logic [4:0] rs2;

    assign rs1 = instr[RS1_MSB:RS1_LSB];
    assign rs2 = instr[RS2_MSB:RS2_LSB];

    // x0 is never a real dependency; inserted NOPs never stall
    always_comb begin
        luse = is_load && (wa != 5'd0) && ((wa == rs1) || (wa == rs2)) && valid;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: owns the PC, handles redirects, load-use stalls and halt drain.
// Latency: instruction at PC appears on INSTR_IFID one cycle later.
// Backpressure: load-use holds PC and IF/ID for one cycle; redirect and halt insert NOPs.
// Optional: define FETCH_PERF_CNT_EN to build the stall/flush performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          IMEM_AW      = 12,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic               CLK,
    input  logic               RSTn,
    output logic [IMEM_AW-1:0] I_MEM_ADDR,
    input  logic [31:0]        I_MEM_DI,
    input  logic               isLoad_IDEX,
    input  logic [4:0]         WA_IDEX,
    input  logic               REDIRECT,
    input  logic [31:0]        REDIRECT_PC,
    input  logic               HALT_ID,
    output logic [31:0]        PC_IFID,
    output logic [31:0]        ADD_PC_IFID,
    output logic [31:0]        INSTR_IFID,
    output logic               VALID_IFID,
    output logic               BUBBLE_ID,
    output logic               HALTED,
    output logic [31:0]        STALL_CNT,
    output logic [31:0]        FLUSH_CNT
);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pc_ifid, pc_ifid_nxt;
    logic [31:0] instr_ifid, instr_ifid_nxt;
    logic        valid_ifid, valid_ifid_nxt;
    logic [3:0]  drain_cnt, drain_cnt_nxt;
    logic        luse;

    hazard_detect u_hazard_detect (
        .is_load (isLoad_IDEX),
        .wa      (WA_IDEX),
        .instr   (instr_ifid),
        .valid   (valid_ifid),
        .luse    (luse)
    );

    assign I_MEM_ADDR  = pc[IMEM_AW-1:0];
    assign PC_IFID     = pc_ifid;
    assign ADD_PC_IFID = pc_ifid + 32'd4;
    assign INSTR_IFID  = instr_ifid;
    assign VALID_IFID  = valid_ifid;
    assign HALTED      = (state == ST_HALTED);
    // HALT itself is not bubbled: it must reach ID/EX so the back end sees it
    assign BUBBLE_ID   = (state == ST_RUN) && (luse || REDIRECT);

    // Next-state and next IF/ID contents; priority redirect > load-use > halt > fetch
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pc_ifid_nxt    = pc_ifid;
        instr_ifid_nxt = instr_ifid;
        valid_ifid_nxt = valid_ifid;
        drain_cnt_nxt  = drain_cnt;
        case (state)
            ST_RUN: begin
                if (REDIRECT) begin
                    pc_nxt         = REDIRECT_PC;
                    instr_ifid_nxt = NOP_INSTR;
                    valid_ifid_nxt = 1'b0;
                end else if (luse) begin
                    // hold PC and IF/ID for one cycle
                end else if (HALT_ID) begin
                    instr_ifid_nxt = NOP_INSTR;
                    valid_ifid_nxt = 1'b0;
                    state_nxt      = ST_DRAIN;
                    drain_cnt_nxt  = 4'(DRAIN_CYCLES - 1);
                end else begin
                    pc_nxt         = pc + 32'd4;
                    pc_ifid_nxt    = pc;
                    instr_ifid_nxt = I_MEM_DI;
                    valid_ifid_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                instr_ifid_nxt = NOP_INSTR;
                valid_ifid_nxt = 1'b0;
                if (drain_cnt == 4'd0) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            default: begin
                // halted: everything holds until reset
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            pc_ifid    <= 32'd0;
            instr_ifid <= NOP_INSTR;
            valid_ifid <= 1'b0;
            drain_cnt  <= 4'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pc_ifid    <= pc_ifid_nxt;
            instr_ifid <= instr_ifid_nxt;
            valid_ifid <= valid_ifid_nxt;
            drain_cnt  <= drain_cnt_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Saturating counts of load-use stall cycles and redirect flushes while running
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (state == ST_RUN) begin
            if (REDIRECT && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (luse && !REDIRECT && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign STALL_CNT = stall_cnt;
    assign FLUSH_CNT = flush_cnt;
`else
    assign STALL_CNT = 32'd0;
    assign FLUSH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a spec-level model checked every cycle.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [11:0] I_MEM_ADDR;
    logic [31:0] I_MEM_DI;
    logic        isLoad_IDEX;
    logic [4:0]  WA_IDEX;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        HALT_ID;
    logic [31:0] PC_IFID, ADD_PC_IFID, INSTR_IFID, STALL_CNT, FLUSH_CNT;
    logic        VALID_IFID, BUBBLE_ID, HALTED;

    logic [31:0] mem [0:1023];

    int vectors = 0;
    int errors  = 0;

    // model state, in spec terms
    bit          m_init = 0;
    logic [31:0] m_pc, m_ifid_pc, m_instr;
    bit          m_valid;
    int          m_mode;       // 0 running, 1 draining, 2 halted
    int          m_left;       // NOP cycles still to issue while draining
    logic [31:0] m_stall, m_flush;

    always #5 CLK = ~CLK;

    assign I_MEM_DI = mem[I_MEM_ADDR[11:2]];

    fetch_stage dut (
        .CLK(CLK), .RSTn(RSTn), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_DI(I_MEM_DI),
        .isLoad_IDEX(isLoad_IDEX), .WA_IDEX(WA_IDEX), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .HALT_ID(HALT_ID), .PC_IFID(PC_IFID),
        .ADD_PC_IFID(ADD_PC_IFID), .INSTR_IFID(INSTR_IFID), .VALID_IFID(VALID_IFID),
        .BUBBLE_ID(BUBBLE_ID), .HALTED(HALTED), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_luse();
        return isLoad_IDEX && (WA_IDEX != 0) &&
               (WA_IDEX == m_instr[19:15] || WA_IDEX == m_instr[24:20]) && m_valid;
    endfunction

    task automatic compare_all();
        logic [31:0] exp_stall, exp_flush;
`ifdef FETCH_PERF_CNT_EN
        exp_stall = m_stall;
        exp_flush = m_flush;
`else
        exp_stall = 0;
        exp_flush = 0;
`endif
        chk("imem_addr", {20'd0, I_MEM_ADDR}, {20'd0, m_pc[11:0]});
        chk("instr", INSTR_IFID, m_instr);
        chk("valid", {31'd0, VALID_IFID}, {31'd0, m_valid});
        if (m_valid) begin
            chk("pc_ifid", PC_IFID, m_ifid_pc);
            chk("add_pc", ADD_PC_IFID, m_ifid_pc + 32'd4);
        end
        chk("bubble", {31'd0, BUBBLE_ID}, {31'd0, (m_mode == 0) && (model_luse() || REDIRECT)});
        chk("halted", {31'd0, HALTED}, {31'd0, m_mode == 2});
        chk("stall_cnt", STALL_CNT, exp_stall);
        chk("flush_cnt", FLUSH_CNT, exp_flush);
    endtask

    task automatic model_edge();
        if (!RSTn) begin
            m_init = 1; m_pc = 0; m_ifid_pc = 0; m_instr = NOP; m_valid = 0;
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_mode == 0) begin
            if (REDIRECT) begin
                m_pc = REDIRECT_PC; m_instr = NOP; m_valid = 0;
                if (m_flush != 32'hFFFF_FFFF) m_flush++;
            end else if (model_luse()) begin
                if (m_stall != 32'hFFFF_FFFF) m_stall++;
            end else if (HALT_ID) begin
                m_instr = NOP; m_valid = 0; m_mode = 1; m_left = 3;
            end else begin
                m_ifid_pc = m_pc; m_instr = mem[m_pc[11:2]]; m_valid = 1; m_pc = m_pc + 4;
            end
        end else if (m_mode == 1) begin
            m_instr = NOP; m_valid = 0; m_left--;
            if (m_left == 0) m_mode = 2;
        end
    endtask

    task automatic drive(input bit rst_n, input bit ld, input logic [4:0] wa,
                         input bit rd, input logic [31:0] rpc, input bit hl);
        RSTn = rst_n; isLoad_IDEX = ld; WA_IDEX = wa;
        REDIRECT = rd; REDIRECT_PC = rpc; HALT_ID = hl;
    endtask

    task automatic tick();
        #2;
        if (m_init) compare_all();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        // addi x0, x7, i : rs1 = x7 everywhere except one add x6,x5,x1 at 0x8
        for (int i = 0; i < 1024; i++) mem[i] = {i[11:0], 5'd7, 3'b000, 5'd0, 7'h13};
        mem[2] = 32'h0012_8333;

        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        tick();
        tick();
        chk("rst_pc_ifid", PC_IFID, 32'h0);
        chk("rst_add_pc", ADD_PC_IFID, 32'h4);
        chk("rst_instr", INSTR_IFID, NOP);
        chk("rst_halted", {31'd0, HALTED}, 32'd0);

        // straight-line fetch
        idle(1);
        chk("sl_pc0", PC_IFID, 32'h0);
        chk("sl_addr4", {20'd0, I_MEM_ADDR}, 32'h4);
        idle(2);
        chk("sl_pc8", PC_IFID, 32'h8);
        chk("sl_add_instr", INSTR_IFID, 32'h0012_8333);
        chk("sl_valid", {31'd0, VALID_IFID}, 32'd1);

        // load x5 in EX against add x6,x5,x1 in ID
        drive(1, 1, 5, 0, 0, 0);
        #1 chk("luse_bubble", {31'd0, BUBBLE_ID}, 32'd1);
        tick();
        chk("luse_hold_pc", PC_IFID, 32'h8);
        chk("luse_hold_addr", {20'd0, I_MEM_ADDR}, 32'hC);
        drive(1, 1, 0, 0, 0, 0);
        #1 chk("x0_no_bubble", {31'd0, BUBBLE_ID}, 32'd0);
        tick();
        chk("x0_advance", PC_IFID, 32'hC);

        // redirect wins over a simultaneous load-use (ID reads x7)
        drive(1, 1, 7, 1, 32'h40, 0);
        #1 chk("rd_bubble", {31'd0, BUBBLE_ID}, 32'd1);
        tick();
        chk("rd_addr", {20'd0, I_MEM_ADDR}, 32'h40);
        chk("rd_instr_nop", INSTR_IFID, NOP);
        chk("rd_valid", {31'd0, VALID_IFID}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rd_flush1", FLUSH_CNT, 32'd1);
        chk("rd_stall1", STALL_CNT, 32'd1);
`else
        chk("rd_flush0", FLUSH_CNT, 32'd0);
        chk("rd_stall0", STALL_CNT, 32'd0);
`endif
        idle(2);
        chk("rd_pc44", PC_IFID, 32'h44);

        // halt together with redirect: redirect taken, still running
        drive(1, 0, 0, 1, 32'h80, 1);
        tick();
        chk("hr_addr", {20'd0, I_MEM_ADDR}, 32'h80);
        idle(2);
        chk("hr_running", PC_IFID, 32'h84);

        // halt alone: three drain cycles, redirects/loads ignored meanwhile
        drive(1, 0, 0, 0, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 7, 1, 32'h100, 0);
            tick();
        end
        chk("halt_set", {31'd0, HALTED}, 32'd1);
        chk("halt_pc_frozen", {20'd0, I_MEM_ADDR}, 32'h88);
        idle(2);
        chk("halt_still", {20'd0, I_MEM_ADDR}, 32'h88);

        // reset from halt, then reset in the middle of a drain
        drive(0, 0, 0, 0, 0, 0);
        tick();
        idle(2);
        drive(1, 0, 0, 0, 0, 1);
        tick();
        idle(1);
        drive(0, 1, 7, 1, 32'h200, 0);
        tick();
        chk("drain_rst_addr", {20'd0, I_MEM_ADDR}, 32'h0);
        chk("drain_rst_halted", {31'd0, HALTED}, 32'd0);
        idle(2);
        chk("resume_pc4", PC_IFID, 32'h4);

        // reset while a load-use stall is pending (ID holds addi x0,x7,1)
        drive(0, 1, 7, 0, 0, 0);
        tick();
        chk("stall_rst_pc", {20'd0, I_MEM_ADDR}, 32'h0);

        // PC wrap at the top of the address space
        drive(1, 0, 0, 1, 32'hFFFF_FFF8, 0);
        tick();
        idle(2);
        chk("wrap_pc", PC_IFID, 32'hFFFF_FFFC);
        chk("wrap_add", ADD_PC_IFID, 32'h0);
        chk("wrap_addr", {20'd0, I_MEM_ADDR}, 32'h0);
        idle(1);
        chk("wrap_pc0", PC_IFID, 32'h0);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
